// File: rtl/uartx_rx.sv
// UARTx 16-bit receiver: two 8N1 frames (low byte first) -> one word with a VALID strobe.
// Build option UARTX_RX_MAJORITY_EN: 3-sample majority vote around each sample point.
module uartx_rx #(
   parameter int BIT_CYCLES = 51,
   parameter int GAP_BITS   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        rx,
   output logic [15:0] DATA,
   output logic        VALID,
   output logic        busy,
   output logic        frame_err,
   output logic        timeout_err
);

   localparam int GAP_CYCLES = GAP_BITS * BIT_CYCLES;
   localparam int CW         = $clog2(GAP_CYCLES + 1);
`ifdef UARTX_RX_MAJORITY_EN
   localparam int OFS = 1;
`else
   localparam int OFS = 0;
`endif
   localparam logic [CW-1:0] START_PT = CW'(BIT_CYCLES / 2 - 1 + OFS);
   localparam logic [CW-1:0] BIT_END  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] GAP_END  = CW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START_CHK, ST_DATA, ST_STOP, ST_GAP, ST_WAIT_HI
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [2:0]      bit_cnt, bit_nxt;
   logic [7:0]      shift, shift_nxt;
   logic [7:0]      low_byte, low_nxt;
   logic            byte_sel, sel_nxt;
   logic [15:0]     data_nxt;
   logic            valid_nxt, ferr_nxt, terr_nxt;
   logic            bit_tick;
   logic            rx_m, rx_s, rx_d;
   logic            fall, sample;

`ifdef UARTX_RX_MAJORITY_EN
   logic rx_d2;
   // Decision one cycle late: rx_d2/rx_d/rx_s cover target-1, target, target+1.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rx_d2 <= 1'b1;
      else        rx_d2 <= rx_d;
   end
   assign sample = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
`else
   assign sample = rx_s;
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rx_m <= 1'b1;
         rx_s <= 1'b1;
         rx_d <= 1'b1;
      end else begin
         rx_m <= rx;
         rx_s <= rx_m;
         rx_d <= rx_s;
      end
   end

   assign fall = rx_d & ~rx_s;
   assign busy = (state != ST_IDLE) | byte_sel;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         low_byte    <= '0;
         byte_sel    <= 1'b0;
         DATA        <= '0;
         VALID       <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         bit_cnt     <= bit_nxt;
         shift       <= shift_nxt;
         low_byte    <= low_nxt;
         byte_sel    <= sel_nxt;
         DATA        <= data_nxt;
         VALID       <= valid_nxt;
         frame_err   <= ferr_nxt;
         timeout_err <= terr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      bit_nxt   = bit_cnt;
      shift_nxt = shift;
      low_nxt   = low_byte;
      sel_nxt   = byte_sel;
      data_nxt  = DATA;
      valid_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      terr_nxt  = 1'b0;
      bit_tick  = 1'b0;
      case (state)
         ST_IDLE: if (fall) state_nxt = ST_START_CHK;
         ST_START_CHK: begin
            if (cnt == START_PT) begin
               if (sample) state_nxt = byte_sel ? ST_GAP : ST_IDLE;
               else begin
                  state_nxt = ST_DATA;
                  bit_nxt   = '0;
               end
            end
         end
         ST_DATA: begin
            if (cnt == BIT_END) begin
               shift_nxt = {sample, shift[7:1]};
               bit_tick  = 1'b1;
               bit_nxt   = bit_cnt + 3'd1;
               if (bit_cnt == 3'd7) state_nxt = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt == BIT_END) begin
               if (!sample) begin
                  ferr_nxt  = 1'b1;
                  sel_nxt   = 1'b0;
                  state_nxt = ST_WAIT_HI;
               end else if (!byte_sel) begin
                  low_nxt   = shift;
                  sel_nxt   = 1'b1;
                  state_nxt = ST_GAP;
               end else begin
                  data_nxt  = {shift, low_byte};
                  valid_nxt = 1'b1;
                  sel_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            // A start edge beats a timeout landing on the same cycle.
            if (fall) state_nxt = ST_START_CHK;
            else if (cnt == GAP_END) begin
               terr_nxt  = 1'b1;
               sel_nxt   = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         ST_WAIT_HI: if (rx_s) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      if (state_nxt != state || bit_tick || state == ST_IDLE || state == ST_WAIT_HI)
         cnt_nxt = '0;
      else
         cnt_nxt = cnt + CW'(1);
   end

endmodule
